counter_seq_arbiter: RTL

Sequencer and arbiter for the shared up/down counter datapath. Two requesters each submit a counting job (start value, end value, direction); the block grants one job at a time, loads the counter, steps it until it reaches the end value, and signals completion. It sits between the control logic issuing count jobs and the counter it owns internally, and is the only agent driving the counter's load/incr/pause controls.

---
 rtl/counter_seq_pkg.sv | 44 ++++
 rtl/updown_counter.sv | 53 +++++
 rtl/counter_seq_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : counter_seq_pkg
//  Description : Shared types and constants for the counter sequencer /
//                arbiter block (counter_seq_arbiter) and its counter
//                datapath (updown_counter).
//                  - seq_state_t : sequencer FSM states
//                  - c_DEFAULT_WIDTH : default counter / job value width
//                  - job_t       : one counting job at the default width
//                  - job_steps() : number of counter steps a job needs
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // A counting job as presented by a requester. The field holding the
    // terminal value cannot be called "end" (reserved word), hence the
    // _val suffixes.
    typedef struct packed {
        logic [c_DEFAULT_WIDTH-1:0] start_val;
        logic [c_DEFAULT_WIDTH-1:0] end_val;
        logic                       up;
    } job_t;

    // Steps from start to end with modulo-2^WIDTH wrap, in the job's
    // direction. Zero when start equals end.
    function automatic logic [c_DEFAULT_WIDTH-1:0] job_steps(input job_t job);
        if (job.up) begin
            return job.end_val - job.start_val;
        end
        return job.start_val - job.end_val;
    endfunction

endpackage : counter_seq_pkg
`default_nettype wire

// File: rtl/updown_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : updown_counter
//  Description : Loadable modulo-2^WIDTH up/down counter. Control priority
//                is load, then pause, then stepping in the direction given
//                by incr.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous active-high reset, clears count
//                data   - value loaded when load is high
//                load   - load data into the counter
//                incr   - step direction: 1 = +1, 0 = -1
//                pause  - hold the current value (ignored while load)
//                count  - current counter value
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             incr,
    input  logic             pause,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Wrap-around falls out of the natural WIDTH-bit arithmetic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= data;
        end else if (!pause) begin
            if (incr) begin
                r_count <= r_count + c_ONE;
            end else begin
                r_count <= r_count - c_ONE;
            end
        end
    end

    assign count = r_count;

endmodule : updown_counter
`default_nettype wire

// File: rtl/counter_seq_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : counter_seq_arbiter
//  Description : Two-requester job sequencer for an internal up/down
//                counter. Grants one counting job at a time, loads the
//                counter with the job's start value, steps it towards the
//                end value and pulses done on completion.
//  Config      : SEQ_ROUND_ROBIN_EN - when defined, ties between the two
//                requesters are broken round-robin (the one not granted
//                last wins); when undefined, requester 0 always wins a tie.
//  Ports       : clk                  - clock, rising edge
//                reset                - synchronous active-high reset
//                req_valid[1:0]       - pending job per requester
//                req_ready[1:0]       - combinational grant (IDLE only)
//                reqN_start/end/up    - job fields of requester N
//                hold                 - pauses stepping in RUN
//                count                - current counter value
//                busy                 - job in progress (LOAD..DONE)
//                owner                - requester of active/last job
//                done, done_id        - completion pulse and its owner
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_arbiter
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_start,
    input  logic [WIDTH-1:0] req1_start,
    input  logic [WIDTH-1:0] req0_end,
    input  logic [WIDTH-1:0] req1_end,
    input  logic             req0_up,
    input  logic             req1_up,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             owner,
    output logic             done,
    output logic             done_id
);

    // Job layout at the configured width (the package type is fixed at
    // the default width).
    typedef struct packed {
        logic [WIDTH-1:0] start_val;
        logic [WIDTH-1:0] end_val;
        logic             up;
    } job_w_t;

    seq_state_t       r_state;
    job_w_t           r_job;
    logic             r_owner;
    logic             r_busy;
    logic             r_done;
    logic             r_done_id;

    logic             w_handshake;
    logic             w_grant_idx;
    job_w_t           w_sel_job;
    logic [WIDTH-1:0] w_count;
    logic             w_load;
    logic             w_at_end;
    logic             w_pause;

`ifdef SEQ_ROUND_ROBIN_EN
    // Index of the requester granted most recently. Reset to 1 so that
    // requester 0 wins the first tie.
    logic             r_last_grant;
`endif

    // ------------------------------------------------------------------
    // Arbitration: only meaningful in IDLE, where req_ready is the
    // handshake itself.
    // ------------------------------------------------------------------
    always_comb begin
`ifdef SEQ_ROUND_ROBIN_EN
        if (req_valid == 2'b11) begin
            w_grant_idx = ~r_last_grant;
        end else begin
            w_grant_idx = req_valid[1];
        end
`else
        w_grant_idx = req_valid[1] & ~req_valid[0];
`endif
        w_handshake = (r_state == IDLE) && (req_valid != 2'b00);

        req_ready = 2'b00;
        if (w_handshake) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        if (w_grant_idx) begin
            w_sel_job.start_val = req1_start;
            w_sel_job.end_val   = req1_end;
            w_sel_job.up        = req1_up;
        end else begin
            w_sel_job.start_val = req0_start;
            w_sel_job.end_val   = req0_end;
            w_sel_job.up        = req0_up;
        end
    end

    // ------------------------------------------------------------------
    // Counter control. The counter resolves load over pause, so hold has
    // no effect in LOAD. Outside RUN (and at the end value) the counter
    // is paused so count holds its value until the next LOAD.
    // ------------------------------------------------------------------
    assign w_load   = (r_state == LOAD);
    assign w_at_end = (w_count == r_job.end_val);
    assign w_pause  = !((r_state == RUN) && !w_at_end && !hold);

    updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .data  (r_job.start_val),
        .load  (w_load),
        .incr  (r_job.up),
        .pause (w_pause),
        .count (w_count)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM with registered status outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_job     <= '0;
            r_owner   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
`ifdef SEQ_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_job   <= w_sel_job;
                        r_owner <= w_grant_idx;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
`ifdef SEQ_ROUND_ROBIN_EN
                        r_last_grant <= w_grant_idx;
`endif
                    end
                end
                LOAD: begin
                    r_state <= RUN;
                end
                RUN: begin
                    // End check comes before hold: a job sitting on its
                    // end value completes even with hold asserted.
                    if (w_at_end) begin
                        r_done    <= 1'b1;
                        r_done_id <= r_owner;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign count   = w_count;
    assign busy    = r_busy;
    assign owner   = r_owner;
    assign done    = r_done;
    assign done_id = r_done_id;

endmodule : counter_seq_arbiter
`default_nettype wire
